// File: rtl/sram_arbiter_pkg.sv
// Shared widths, owner encoding and tag layout for the SRAM arbiter.
package sram_arbiter_pkg;

    localparam int SRAM_AW  = 64;
    localparam int SRAM_DW  = 64;
    localparam int SRAM_SW  = 8;
    localparam int STREAK_W = 3;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/sram_tag_pipe.sv
// Latency-matched shift register of {valid, owner} tags; the last stage lines
// up with the SRAM read data of the access that loaded stage 0.
module sram_tag_pipe
    import sram_arbiter_pkg::*;
#(
    parameter int SRAM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [SRAM_LAT-1:0] stage_q;
    tag_t [SRAM_LAT-1:0] stage_d;

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < SRAM_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: every tag is cleared on reset so an access issued before reset can
    // never surface as a response afterwards; non-blocking keeps the shift ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[SRAM_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single-ported SRAM between the fetch (inst) and memory (data)
// ports: data wins, a saturating streak counter bounds instruction starvation.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int SRAM_LAT   = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic [SRAM_AW-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [SRAM_DW-1:0] inst_rdata,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [SRAM_SW-1:0] data_wstrb,
    input  logic [SRAM_AW-1:0] data_addr,
    input  logic [SRAM_DW-1:0] data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [SRAM_DW-1:0] data_rdata,
    output logic               sram_en,
    output logic [SRAM_SW-1:0] sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

    logic                grant_inst;
    logic                grant_data;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    tag_t                tag_in;
    tag_t                tag_out;

    // NOTE: defaults first in every always_comb so no path leaves a signal
    // unassigned and infers a latch.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (reset) begin
            if (data_req && !(inst_req && streak_q == STREAK_LIMIT)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    // Counts data grants that jumped a waiting instruction request.
    always_comb begin
        streak_d = streak_q;
        if (!inst_req || grant_inst) begin
            streak_d = '0;
        end else if (grant_data && streak_q != '1) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    always_comb begin
        sram_en      = grant_inst | grant_data;
        sram_we      = (grant_data && data_wr) ? data_wstrb : '0;
        sram_addr    = {(grant_data ? data_addr[SRAM_AW-1:3] : inst_addr[SRAM_AW-1:3]), 3'b000};
        sram_wdata   = data_wdata;
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        tag_in.valid = grant_inst | grant_data;
        tag_in.owner = grant_data ? OWN_DATA : OWN_INST;
    end

    sram_tag_pipe #(
        .SRAM_LAT (SRAM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign inst_data_ok = tag_out.valid && (tag_out.owner == OWN_INST);
    assign data_data_ok = tag_out.valid && (tag_out.owner == OWN_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

endmodule
